// File: rtl/trace_pkg.sv
// Shared types for the trace recorder: event kinds, recorder states and the
// packed trace entry written to the trace RAM.
package trace_pkg;

  // Entry field widths; the recorder's width parameters must match these.
  localparam int TRACE_ADDR_W = 32;
  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_TS_W   = 32;
  // Channel ID field wide enough for the maximum of eight channels.
  localparam int CH_W         = 3;

  typedef enum logic [2:0] {
    EV_LOAD_REQ   = 3'd0,
    EV_LOAD_DATA  = 3'd1,
    EV_STORE_REQ  = 3'd2,
    EV_STORE_DONE = 3'd3,
    EV_INVALIDATE = 3'd4
  } event_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [TRACE_TS_W-1:0]   timestamp;
    logic [CH_W-1:0]         channel;
    event_kind_t             kind;
    logic [TRACE_ADDR_W-1:0] address;
    logic [TRACE_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// current priority pointer; the pointer moves just past each granted channel.
module trace_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clear_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] prio_q, prio_d;

  // Pick the first requester scanning upward from the priority pointer.
  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    gnt_o  = '0;
    prio_d = prio_q;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(prio_q) + i;
      if (idx >= N) idx = idx - N;
      if (req_i[PW'(idx)] && (gnt_o == '0)) begin
        gnt_o[PW'(idx)] = 1'b1;
        prio_d          = (idx == N - 1) ? PW'(0) : PW'(idx + 1);
      end
    end
  end

  // Priority pointer register; restarts at channel 0 on reset or clear.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n_i || clear_i) prio_q <= '0;
    else                     prio_q <= prio_d;
  end

endmodule

// File: rtl/trace_recorder.sv
// Trace recorder: timestamps events from several memory channels, holds each
// in a per-channel register, arbitrates them into a circular trace RAM and
// offers random-access readout relative to the oldest stored entry.
module trace_recorder
  import trace_pkg::*;
#(
  parameter int  CHANNELS   = 4,
  parameter int  DEPTH      = 256,
  parameter int  ADDR_WIDTH = TRACE_ADDR_W,
  parameter int  DATA_WIDTH = TRACE_DATA_W,
  parameter int  TS_WIDTH   = TRACE_TS_W,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int CNT_W      = IDX_W + 1,
  localparam int ENTRY_W    = $bits(trace_entry_t)
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [CHANNELS-1:0]            ev_valid_i,
  input  logic [CHANNELS*3-1:0]          ev_kind_i,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] ev_address_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] ev_data_i,
  input  logic                           arm_i,
  input  logic                           clear_i,
  input  logic                           wrap_mode_i,
  input  logic [ADDR_WIDTH-1:0]          trig_address_i,
  input  logic [ADDR_WIDTH-1:0]          trig_mask_i,
  input  logic                           stop_i,
  input  logic                           rd_en_i,
  input  logic [IDX_W-1:0]               rd_index_i,
  output logic                           rd_valid_o,
  output logic                           rd_error_o,
  output logic [ENTRY_W-1:0]             rd_entry_o,
  output logic [1:0]                     state_o,
  output logic [CNT_W-1:0]               count_o,
  output logic                           wrapped_o,
  output logic [15:0]                    dropped_o
);

  trace_state_t          state_q, state_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wrapped_q, wrapped_d;
  logic [15:0]           dropped_q, dropped_d;
  logic                  wrap_mode_q, wrap_mode_d;
  logic [CHANNELS-1:0]   occ_q, occ_d;
  trace_entry_t          hold_q [CHANNELS];
  trace_entry_t          hold_d [CHANNELS];
  logic                  rd_valid_q, rd_error_q;
  trace_entry_t          ram_rdata_q;
  trace_entry_t          ram [DEPTH];

  logic                  arm_ok, trig_hit, wr_en, going_done, load_en, rd_reject;
  logic [CHANNELS-1:0]   arb_req, gnt, drop_vec;
  logic [3:0]            drop_cnt;
  logic [16:0]           drop_sum;
  trace_entry_t          wr_entry;
  logic [IDX_W-1:0]      rd_phys;

  assign arm_ok  = arm_i && !clear_i && (state_q == ST_IDLE || state_q == ST_DONE);
  assign arb_req = occ_q & {CHANNELS{state_q == ST_CAPTURE}};
  // Reset and clear suppress the write that would otherwise land this cycle.
  assign wr_en   = (state_q == ST_CAPTURE) && (|gnt) && rst_n_i && !clear_i;
  // Stop mode finishes on the write that fills the last free slot.
  assign going_done = (state_q == ST_CAPTURE) &&
                      (stop_i || (!wrap_mode_q && wr_en && count_q == CNT_W'(DEPTH - 1)));
  // Events are taken in the triggering cycle and throughout capture.
  assign load_en = (state_q == ST_ARMED && trig_hit) ||
                   (state_q == ST_CAPTURE && !going_done);

  trace_rr_arbiter #(.N(CHANNELS)) u_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (clear_i | arm_ok),
    .req_i   (arb_req),
    .gnt_o   (gnt)
  );

  // Trigger match on any valid event under the address mask.
  always_comb begin
    trig_hit = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ev_valid_i[c] &&
          (((ev_address_i[c*ADDR_WIDTH +: ADDR_WIDTH] ^ trig_address_i) & trig_mask_i) == '0))
        trig_hit = 1'b1;
    end
  end

  // Next-state logic for the recorder FSM; clear overrides everything.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (arm_i)      state_d = ST_ARMED;
        ST_ARMED:         if (trig_hit)   state_d = ST_CAPTURE;
        ST_CAPTURE:       if (going_done) state_d = ST_DONE;
        default:                          state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Holder loading, drop detection and granted-entry selection.
  always_comb begin
    trace_entry_t ev_entry;
    occ_d    = occ_q;
    hold_d   = hold_q;
    drop_vec = '0;
    drop_cnt = '0;
    wr_entry = '0;
    ev_entry = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ev_entry.timestamp = ts_q;
      ev_entry.channel   = CH_W'(c);
      ev_entry.kind      = event_kind_t'(ev_kind_i[c*3 +: 3]);
      ev_entry.address   = ev_address_i[c*ADDR_WIDTH +: ADDR_WIDTH];
      ev_entry.data      = ev_data_i[c*DATA_WIDTH +: DATA_WIDTH];
      if (gnt[c]) wr_entry = hold_q[c];
      if (clear_i || arm_ok || going_done) begin
        occ_d[c] = 1'b0;
      end else if (load_en && ev_valid_i[c] && (!occ_q[c] || gnt[c])) begin
        occ_d[c]  = 1'b1;
        hold_d[c] = ev_entry;
      end else begin
        if (load_en && ev_valid_i[c]) drop_vec[c] = 1'b1;
        if (gnt[c])                   occ_d[c]    = 1'b0;
      end
      if (drop_vec[c]) drop_cnt = drop_cnt + 4'd1;
    end
  end

  assign drop_sum = {1'b0, dropped_q} + 17'(drop_cnt);

  // Timestamp, write pointer, fill count and status next-state values.
  always_comb begin
    ts_d        = ts_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    wrapped_d   = wrapped_q;
    dropped_d   = dropped_q;
    wrap_mode_d = wrap_mode_q;
    if (clear_i) begin
      ts_d      = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      wrapped_d = 1'b0;
      dropped_d = '0;
    end else if (arm_ok) begin
      ts_d        = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      wrapped_d   = 1'b0;
      dropped_d   = '0;
      wrap_mode_d = wrap_mode_i;
    end else begin
      if (state_q == ST_ARMED || state_q == ST_CAPTURE) ts_d = ts_q + 1'b1;
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q == CNT_W'(DEPTH)) wrapped_d = 1'b1;
        else                          count_d   = count_q + 1'b1;
      end
      dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Control and status registers, including the read response flags.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      dropped_q   <= '0;
      wrap_mode_q <= 1'b0;
      occ_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_error_q  <= 1'b0;
    end else begin
      ts_q        <= ts_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wrapped_q   <= wrapped_d;
      dropped_q   <= dropped_d;
      wrap_mode_q <= wrap_mode_d;
      occ_q       <= occ_d;
      rd_valid_q  <= rd_en_i;
      rd_error_q  <= rd_en_i && rd_reject;
    end
  end

  // Holder payloads; meaningful only while the matching occupancy bit is set.
  always_ff @(posedge clk_i) begin
    hold_q <= hold_d;
  end

  // Oldest entry sits count entries behind the write pointer (mod DEPTH).
  assign rd_phys   = wr_ptr_q - count_q[IDX_W-1:0] + rd_index_i;
  assign rd_reject = (state_q == ST_CAPTURE) || ({1'b0, rd_index_i} >= count_q);

  // Simple dual-port trace RAM: one write port, one registered read port.
  always_ff @(posedge clk_i) begin
    // NOTE: the RAM array is deliberately not reset so it maps onto block RAM;
    // validity is tracked by count_q, never by the storage contents.
    if (wr_en) ram[wr_ptr_q] <= wr_entry;
    ram_rdata_q <= ram[rd_phys];
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_error_o = rd_error_q;
  assign rd_entry_o = (rd_valid_q && !rd_error_q) ? ram_rdata_q : '0;
  assign state_o    = state_q;
  assign count_o    = count_q;
  assign wrapped_o  = wrapped_q;
  assign dropped_o  = dropped_q;

endmodule
